bp_me_lite_gearbox_stream: RTL and testbench

Registered, bidirectional BedRock-lite memory-message width converter. It converts between a wide single-beat side and a narrow multi-beat stream side: wide→narrow serialises and wide←narrow gathers. It supports every transfer size, increments addresses per beat and drives a last-beat flag. It sits between the BlackParrot I/O or memory port and host-side bridges whose data widths differ.

---
 rtl/bp_me_lite_gearbox_stream.sv | 190 +++++++++++++++++++
 tb/tb_bp_me_lite_gearbox_stream.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_lite_gearbox_stream.sv
// rtl/bp_me_lite_gearbox_stream.sv - registered memory-message width converter (serialise / gather)
module bp_me_lite_gearbox_stream #(
    parameter int paddr_width_p    = 40,
    parameter int msg_type_width_p = 4,
    parameter int size_width_p     = 3,
    parameter int in_data_width_p  = 512,
    parameter int out_data_width_p = 64,
    parameter logic [(1<<msg_type_width_p)-1:0] payload_mask_p = '0,
    localparam int header_width_lp = msg_type_width_p + size_width_p + paddr_width_p
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [header_width_lp-1:0]  mem_header_i,
    input  logic [in_data_width_p-1:0]  mem_data_i,
    input  logic                        mem_v_i,
    output logic                        mem_ready_and_o,
    output logic [header_width_lp-1:0]  mem_header_o,
    output logic [out_data_width_p-1:0] mem_data_o,
    output logic                        mem_v_o,
    input  logic                        mem_ready_and_i,
    output logic                        mem_last_o
);

    localparam int AW  = paddr_width_p;
    localparam int SW  = size_width_p;
    localparam int TW  = msg_type_width_p;
    localparam int HW  = header_width_lp;
    localparam int W   = (in_data_width_p > out_data_width_p) ? in_data_width_p : out_data_width_p;
    localparam int N   = (in_data_width_p > out_data_width_p) ? out_data_width_p : in_data_width_p;
    localparam int R   = W / N;
    localparam int NB  = $clog2(N / 8);
    localparam int LGR = $clog2(R);
    localparam int CW  = (LGR > 0) ? LGR : 1;
    localparam int LGW = (LGR > 0) ? $clog2(LGR + 1) : 1;

    typedef enum logic {S_IDLE, S_SEND} state_e;

    // log2 of the narrow-side beat count of a message, capped at log2(R)
    function automatic logic [LGW-1:0] beats_lg(input logic [HW-1:0] h);
        int sz;
        int typ;
        int d;
        sz  = int'(h[AW +: SW]);
        typ = int'(h[AW+SW +: TW]);
        d   = 0;
        if (payload_mask_p[typ] && sz > NB) d = sz - NB;
        if (d > LGR) d = LGR;
        return LGW'(d);
    endfunction

    if (in_data_width_p > out_data_width_p) begin : g_down
        state_e            state_r, state_n;
        logic [HW-1:0]     hdr_r;
        logic [W-1:0]      data_r;
        logic [CW-1:0]     cnt_r;
        logic [LGW-1:0]    lg_r;
        logic              last_beat;

        assign last_beat       = (int'(cnt_r) == (1 << lg_r) - 1);
        assign mem_ready_and_o = (state_r == S_IDLE) && reset_n_i;
        assign mem_v_o         = (state_r == S_SEND);
        assign mem_last_o      = mem_v_o && last_beat;
        assign mem_header_o    = {hdr_r[HW-1:AW], hdr_r[AW-1:0] + AW'(int'(cnt_r) * (N / 8))};
        assign mem_data_o      = data_r[int'(cnt_r)*N +: N];

        // state register
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) state_r <= S_IDLE;
            else            state_r <= state_n;
        end

        // accept one wide message, then emit its beats until the last one leaves
        always_comb begin
            state_n = state_r;
            case (state_r)
                S_IDLE: if (mem_v_i)                       state_n = S_SEND;
                S_SEND: if (mem_ready_and_i && last_beat)  state_n = S_IDLE;
                default:                                   state_n = S_IDLE;
            endcase
        end

        // beat counter, advanced on each output handshake
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i)                 cnt_r <= '0;
            else if (state_r == S_IDLE)     cnt_r <= '0;
            else if (mem_ready_and_i)       cnt_r <= last_beat ? '0 : cnt_r + 1'b1;
        end

        // payload capture; contents are meaningless until the first message arrives
        always_ff @(posedge clk_i) begin
            if (state_r == S_IDLE && mem_v_i) begin
                hdr_r  <= mem_header_i;
                data_r <= mem_data_i;
                lg_r   <= beats_lg(mem_header_i);
            end
        end
    end else if (in_data_width_p < out_data_width_p) begin : g_up
        state_e            state_r, state_n;
        logic [HW-1:0]     hdr_r;
        logic [W-1:0]      buf_r;
        logic [CW-1:0]     cnt_r;
        logic [LGW-1:0]    lg_r;
        logic [LGW-1:0]    lg_cur;
        logic              last_in;

        // the first beat defines the message length; later headers are ignored
        assign lg_cur          = (cnt_r == '0) ? beats_lg(mem_header_i) : lg_r;
        assign last_in         = (int'(cnt_r) == (1 << lg_cur) - 1);
        assign mem_ready_and_o = (state_r == S_IDLE) && reset_n_i;
        assign mem_v_o         = (state_r == S_SEND);
        assign mem_last_o      = mem_v_o;
        assign mem_header_o    = hdr_r;

        // short messages are replicated across the whole wide word
        always_comb begin
            mem_data_o = '0;
            for (int j = 0; j < R; j++) begin
                mem_data_o[j*N +: N] = buf_r[(j & ((1 << lg_r) - 1))*N +: N];
            end
        end

        // state register
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) state_r <= S_IDLE;
            else            state_r <= state_n;
        end

        // gather beats until the last one, then hold the wide word until taken
        always_comb begin
            state_n = state_r;
            case (state_r)
                S_IDLE: if (mem_v_i && last_in)  state_n = S_SEND;
                S_SEND: if (mem_ready_and_i)     state_n = S_IDLE;
                default:                         state_n = S_IDLE;
            endcase
        end

        // lane counter, advanced on each input handshake
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i)                          cnt_r <= '0;
            else if (state_r == S_IDLE && mem_v_i)   cnt_r <= last_in ? '0 : cnt_r + 1'b1;
        end

        // lane write plus first-beat header capture
        always_ff @(posedge clk_i) begin
            if (state_r == S_IDLE && mem_v_i) begin
                buf_r[int'(cnt_r)*N +: N] <= mem_data_i;
                if (cnt_r == '0) begin
                    hdr_r <= mem_header_i;
                    lg_r  <= lg_cur;
                end
            end
        end
    end else begin : g_bypass
        state_e                     state_r, state_n;
        logic [HW-1:0]              hdr_r;
        logic [in_data_width_p-1:0] data_r;

        assign mem_ready_and_o = (state_r == S_IDLE) && reset_n_i;
        assign mem_v_o         = (state_r == S_SEND);
        assign mem_last_o      = mem_v_o;
        assign mem_header_o    = hdr_r;
        assign mem_data_o      = data_r;

        // state register
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) state_r <= S_IDLE;
            else            state_r <= state_n;
        end

        // single-entry register slice
        always_comb begin
            state_n = state_r;
            case (state_r)
                S_IDLE: if (mem_v_i)          state_n = S_SEND;
                S_SEND: if (mem_ready_and_i)  state_n = S_IDLE;
                default:                      state_n = S_IDLE;
            endcase
        end

        // message capture
        always_ff @(posedge clk_i) begin
            if (state_r == S_IDLE && mem_v_i) begin
                hdr_r  <= mem_header_i;
                data_r <= mem_data_i;
            end
        end
    end

endmodule

// File: tb/tb_bp_me_lite_gearbox_stream.sv
// tb/tb_bp_me_lite_gearbox_stream.sv - scoreboard bench for downshift and upshift gearbox instances
module tb_bp_me_lite_gearbox_stream;

    localparam int HW = 47;

    typedef struct packed {
        logic [HW-1:0] hdr;
        logic [63:0]   data;
        logic          last;
    } dn_beat_t;

    typedef struct packed {
        logic [HW-1:0] hdr;
        logic [511:0]  data;
        logic          last;
    } up_beat_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [HW-1:0]  dn_hdr_i, dn_hdr_o;
    logic [511:0]   dn_data_i;
    logic [63:0]    dn_data_o;
    logic           dn_v_i, dn_rdy_o, dn_v_o, dn_rdy_i, dn_last_o;

    logic [HW-1:0]  up_hdr_i, up_hdr_o;
    logic [63:0]    up_data_i;
    logic [511:0]   up_data_o;
    logic           up_v_i, up_rdy_o, up_v_o, up_rdy_i, up_last_o;

    dn_beat_t dn_q[$];
    up_beat_t up_q[$];
    int checks = 0;
    int errors = 0;
    int dn_popped = 0;
    int dn_mode = 0;
    int up_mode = 0;

    always #5 clk = ~clk;

    bp_me_lite_gearbox_stream #(
        .in_data_width_p(512), .out_data_width_p(64), .payload_mask_p(16'h0002)
    ) u_dn (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_header_i(dn_hdr_i), .mem_data_i(dn_data_i), .mem_v_i(dn_v_i), .mem_ready_and_o(dn_rdy_o),
        .mem_header_o(dn_hdr_o), .mem_data_o(dn_data_o), .mem_v_o(dn_v_o), .mem_ready_and_i(dn_rdy_i),
        .mem_last_o(dn_last_o)
    );

    bp_me_lite_gearbox_stream #(
        .in_data_width_p(64), .out_data_width_p(512), .payload_mask_p(16'h0002)
    ) u_up (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_header_i(up_hdr_i), .mem_data_i(up_data_i), .mem_v_i(up_v_i), .mem_ready_and_o(up_rdy_o),
        .mem_header_o(up_hdr_o), .mem_data_o(up_data_o), .mem_v_o(up_v_o), .mem_ready_and_i(up_rdy_i),
        .mem_last_o(up_last_o)
    );

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] s, input logic [39:0] a);
        return {t, s, a};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_dn(input logic [HW-1:0] h, input logic [63:0] d, input logic l);
        dn_beat_t b;
        b.hdr = h; b.data = d; b.last = l;
        dn_q.push_back(b);
    endtask

    task automatic push_up(input logic [HW-1:0] h, input logic [511:0] d);
        up_beat_t b;
        b.hdr = h; b.data = d; b.last = 1'b1;
        up_q.push_back(b);
    endtask

    // downstream ready patterns: 0 always ready, 1 random, 2 stalled
    initial begin
        dn_rdy_i = 1'b1;
        up_rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dn_rdy_i = (dn_mode == 0) ? 1'b1 : (dn_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            up_rdy_i = (up_mode == 0) ? 1'b1 : (up_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // narrow-side monitor
    always @(negedge clk) begin
        if (rst_n && dn_v_o && dn_rdy_i) begin
            if (dn_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL dn_unexpected_beat: got hdr=%h data=%h, required no beat", dn_hdr_o, dn_data_o);
            end else begin
                dn_beat_t e;
                e = dn_q.pop_front();
                check("dn_beat", {dn_hdr_o, dn_data_o, dn_last_o}, {e.hdr, e.data, e.last});
            end
            dn_popped++;
        end
    end

    // wide-side monitor
    always @(negedge clk) begin
        if (rst_n && up_v_o && up_rdy_i) begin
            if (up_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL up_unexpected_msg: got hdr=%h, required no message", up_hdr_o);
            end else begin
                up_beat_t e;
                e = up_q.pop_front();
                check("up_hdr", up_hdr_o, e.hdr);
                check("up_data", up_data_o, e.data);
                check("up_last", up_last_o, e.last);
            end
        end
    end

    task automatic dn_send(input logic [HW-1:0] h, input logic [511:0] d);
        int t;
        @(posedge clk); #1;
        dn_hdr_i = h; dn_data_i = d; dn_v_i = 1'b1;
        t = 0;
        @(negedge clk);
        while (!dn_rdy_o && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin checks++; errors++; $display("FAIL dn_send_timeout: ready=%b required 1", dn_rdy_o); end
        @(posedge clk); #1;
        dn_v_i = 1'b0;
    endtask

    task automatic up_send(input logic [HW-1:0] h, input logic [63:0] d);
        int t;
        @(posedge clk); #1;
        up_hdr_i = h; up_data_i = d; up_v_i = 1'b1;
        t = 0;
        @(negedge clk);
        while (!up_rdy_o && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin checks++; errors++; $display("FAIL up_send_timeout: ready=%b required 1", up_rdy_o); end
        @(posedge clk); #1;
        up_v_i = 1'b0;
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while ((dn_q.size() != 0 || up_q.size() != 0) && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending dn=%0d up=%0d required 0", dn_q.size(), up_q.size());
        end
    endtask

    task automatic wait_popped(input int target);
        int t;
        t = 0;
        while (dn_popped < target && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) begin checks++; errors++; $display("FAIL popped_timeout: got %0d required %0d", dn_popped, target); end
    endtask

    // lane k = {tag + k, k} for an 8-lane wide word
    function automatic logic [511:0] lane_pat(input logic [31:0] tag);
        logic [511:0] d;
        for (int k = 0; k < 8; k++) d[64*k +: 64] = {tag + 32'(k), 32'(k)};
        return d;
    endfunction

    initial begin
        logic [511:0] d;
        logic [511:0] ew;
        logic [63:0]  eb;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [HW+64:0] snap;
        int p0;

        rst_n = 1'b0;
        dn_v_i = 1'b0; dn_hdr_i = '0; dn_data_i = '0;
        up_v_i = 1'b0; up_hdr_i = '0; up_data_i = '0;

        // reset state
        #2;
        check("rst_dn_v", dn_v_o, 1'b0);
        check("rst_dn_last", dn_last_o, 1'b0);
        check("rst_dn_ready", dn_rdy_o, 1'b0);
        check("rst_up_v", up_v_o, 1'b0);
        check("rst_up_ready", up_rdy_o, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_dn_ready", dn_rdy_o, 1'b1);
        check("post_rst_up_ready", up_rdy_o, 1'b1);

        // 64B write serialised into 8 beats, bytes 0..63
        for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) eb[8*j +: 8] = 8'(8*k + j);
            push_dn(mk_hdr(4'd1, 3'd6, 40'h80_0000_0000 + 40'(8*k)), eb, k == 7);
        end
        dn_send(mk_hdr(4'd1, 3'd6, 40'h80_0000_0000), d);
        @(negedge clk);
        check("dn_first_beat_latency", dn_v_o, 1'b1);
        wait_empty();

        // 16B write: two beats; then a non-payload read: one beat
        d = {16{32'hDEADBEEF}};
        d[63:0]    = 64'h0123_4567_89AB_CDEF;
        d[127:64]  = 64'hFEDC_BA98_7654_3210;
        push_dn(mk_hdr(4'd1, 3'd4, 40'h100), 64'h0123_4567_89AB_CDEF, 1'b0);
        push_dn(mk_hdr(4'd1, 3'd4, 40'h108), 64'hFEDC_BA98_7654_3210, 1'b1);
        dn_send(mk_hdr(4'd1, 3'd4, 40'h100), d);
        d[63:0] = 64'h5555_AAAA_5555_AAAA;
        push_dn(mk_hdr(4'd0, 3'd6, 40'h200), 64'h5555_AAAA_5555_AAAA, 1'b1);
        dn_send(mk_hdr(4'd0, 3'd6, 40'h200), d);
        wait_empty();

        // 5-cycle stall mid-message, outputs must hold
        d = lane_pat(32'hC0DE_0000);
        for (int k = 0; k < 8; k++)
            push_dn(mk_hdr(4'd1, 3'd6, 40'h4000 + 40'(8*k)), {32'hC0DE_0000 + 32'(k), 32'(k)}, k == 7);
        p0 = dn_popped;
        dn_send(mk_hdr(4'd1, 3'd6, 40'h4000), d);
        wait_popped(p0 + 3);
        dn_mode = 2;
        @(posedge clk); #2;
        snap = {dn_hdr_o, dn_data_o, dn_v_o};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("dn_stall_stable", {dn_hdr_o, dn_data_o, dn_v_o}, snap);
        end
        dn_mode = 1;
        wait_empty();

        // random ready on back-to-back messages
        d = lane_pat(32'h7700_0000);
        for (int k = 0; k < 8; k++)
            push_dn(mk_hdr(4'd1, 3'd6, 40'h6000 + 40'(8*k)), {32'h7700_0000 + 32'(k), 32'(k)}, k == 7);
        dn_send(mk_hdr(4'd1, 3'd6, 40'h6000), d);
        push_dn(mk_hdr(4'd1, 3'd4, 40'h7000), {32'h7700_0000, 32'd0}, 1'b0);
        push_dn(mk_hdr(4'd1, 3'd4, 40'h7008), {32'h7700_0001, 32'd1}, 1'b1);
        dn_send(mk_hdr(4'd1, 3'd4, 40'h7000), d);
        wait_empty();
        dn_mode = 0;

        // reset in the middle of an 8-beat message
        d = lane_pat(32'hBAD0_0000);
        for (int k = 0; k < 8; k++)
            push_dn(mk_hdr(4'd1, 3'd6, 40'h5000 + 40'(8*k)), {32'hBAD0_0000 + 32'(k), 32'(k)}, k == 7);
        p0 = dn_popped;
        dn_send(mk_hdr(4'd1, 3'd6, 40'h5000), d);
        wait_popped(p0 + 3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("dn_v_async_reset", dn_v_o, 1'b0);
        check("dn_ready_in_reset", dn_rdy_o, 1'b0);
        dn_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("dn_no_partial_after_reset", dn_v_o, 1'b0);
        check("dn_ready_after_reset", dn_rdy_o, 1'b1);
        d = lane_pat(32'h900D_0000);
        for (int k = 0; k < 8; k++)
            push_dn(mk_hdr(4'd1, 3'd6, 40'h9000 + 40'(8*k)), {32'h900D_0000 + 32'(k), 32'(k)}, k == 7);
        dn_send(mk_hdr(4'd1, 3'd6, 40'h9000), d);
        wait_empty();

        // upshift: 8 beats gathered into one wide message
        ew = lane_pat(32'hA5A5_0000);
        push_up(mk_hdr(4'd1, 3'd6, 40'h1000), ew);
        up_mode = 2;
        for (int k = 0; k < 8; k++)
            up_send(mk_hdr(4'd1, 3'd6, 40'h1000 + 40'(8*k)), ew[64*k +: 64]);
        @(negedge clk);
        check("up_valid_after_last", up_v_o, 1'b1);
        check("up_ready_in_send", up_rdy_o, 1'b0);
        @(negedge clk);
        check("up_ready_in_send_hold", up_rdy_o, 1'b0);
        up_mode = 0;
        wait_empty();

        // upshift 16B: {B,A} replicated four times
        a = 64'hAAAA_0000_AAAA_0001;
        b = 64'hBBBB_0000_BBBB_0002;
        push_up(mk_hdr(4'd1, 3'd4, 40'h2000), {4{b, a}});
        up_send(mk_hdr(4'd1, 3'd4, 40'h2000), a);
        up_send(mk_hdr(4'd1, 3'd4, 40'h2008), b);
        wait_empty();

        // upshift non-payload: single beat replicated eight times
        a = 64'hC3C3_1234_5678_9ABC;
        push_up(mk_hdr(4'd0, 3'd3, 40'h3000), {8{a}});
        up_send(mk_hdr(4'd0, 3'd3, 40'h3000), a);
        wait_empty();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
